// File: rtl/cfg_chain_writer_pkg.sv
// Types for the config chain writer.
package cfg_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SETUP,
        PULSE,
        DONE
    } cfg_wr_state_t;
endpackage

// File: rtl/fp_pkg.sv
// Shared fixed-point word definitions used across the neuromorphic config path.
package fp;
    localparam int WORD_LENGTH = 16;
    typedef logic [WORD_LENGTH-1:0] fpType;
endpackage

// File: rtl/cfg_chain_writer_if.sv
// Config shift-chain link: bit-parallel word plus its shift clock.
interface config_if;
    logic      data_clk;
    fp::fpType data_in;

    modport master (output data_clk, output data_in);
    modport slave  (input  data_clk, input  data_in);
endinterface

// File: rtl/cfg_chain_writer_phase_cnt.sv
// Loadable down-counter timing the SETUP and PULSE phases of data_clk.
module cfg_phase_cnt #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tc
);
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/cfg_chain_writer.sv
// Master end of the config_if shift chain: streams CHAIN_LEN host words into the chain.
// Optional tail readback is enabled with `define CFG_CHAIN_READBACK_EN.
module cfg_chain_writer
    import cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  fp::fpType                      in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] word_cnt,
`ifdef CFG_CHAIN_READBACK_EN
    config_if.slave                        cfg_in,
    output fp::fpType                      rd_data,
    output logic                           rd_valid,
`endif
    config_if.master                       cfg_out
);
    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned PW = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] PHASE_LOAD = PW'(CLK_DIV - 1);

    cfg_wr_state_t state;
    logic          ph_load;
    logic          ph_en;
    logic          ph_tc;

    // Reload on entry to each phase so SETUP and PULSE both last CLK_DIV cycles.
    always_comb begin
        ph_load = 1'b0;
        ph_en   = 1'b0;
        case (state)
            WAIT_WORD: ph_load = in_valid && in_ready;
            SETUP: begin
                ph_en   = 1'b1;
                ph_load = ph_tc;
            end
            PULSE:   ph_en = 1'b1;
            default: ;
        endcase
    end

    cfg_phase_cnt #(.WIDTH(PW)) u_phase_cnt (
        .clk      (clk),
        .rst      (reset),
        .load     (ph_load),
        .load_val (PHASE_LOAD),
        .en       (ph_en),
        .tc       (ph_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cfg_out.data_clk <= 1'b0;
            cfg_out.data_in  <= '0;
            in_ready         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            word_cnt         <= '0;
`ifdef CFG_CHAIN_READBACK_EN
            rd_data          <= '0;
            rd_valid         <= 1'b0;
`endif
        end else begin
`ifdef CFG_CHAIN_READBACK_EN
            rd_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_WORD;
                        word_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (in_valid && in_ready) begin
                        cfg_out.data_in <= in_data;
                        in_ready        <= 1'b0;
                        state           <= SETUP;
                    end
                end
                SETUP: begin
                    if (ph_tc) begin
                        cfg_out.data_clk <= 1'b1;
                        state            <= PULSE;
                    end
                end
                PULSE: begin
                    if (ph_tc) begin
                        cfg_out.data_clk <= 1'b0;
                        word_cnt         <= word_cnt + CW'(1);
`ifdef CFG_CHAIN_READBACK_EN
                        // Tail still shows its pre-shift word until data_clk falls.
                        rd_data  <= cfg_in.data_in;
                        rd_valid <= 1'b1;
`endif
                        if (word_cnt + CW'(1) < CW'(CHAIN_LEN)) begin
                            state    <= WAIT_WORD;
                            in_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cfg_chain_writer.md
Name: cfg_chain_writer

Overview:
- Master end of the config_if shift chain.
- Takes configuration words from a host valid/ready stream and shifts them into a daisy chain of config_if slaves (synapses, dendrites). It generates data_clk from clk and drives data_in around each data_clk rising edge.
- One transaction shifts exactly CHAIN_LEN words. The first word accepted ends up in the far end of the chain.

Parameters:
- CHAIN_LEN, 64, number of words (data_clk pulses) per transaction; >= 1.
- CLK_DIV, 2, clk cycles per data_clk phase (low setup phase and high phase each); >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- start  input  1  begin a transaction; sampled only in IDLE
- in_data  input  fp::WORD_LENGTH  config word (fp::fpType)
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at end of transaction
- word_cnt  output  $clog2(CHAIN_LEN+1)  words shifted so far in current transaction
- cfg_out  config_if.master  -  drives data_clk and data_in (fp::WORD_LENGTH) into the chain head

Behaviour:
- Reset values: state IDLE; cfg_out.data_clk 0; cfg_out.data_in 0; in_ready 0; busy 0; done 0; word_cnt 0; phase counter 0. Reset is async, so data_clk drops to 0 immediately even mid-pulse.
- All outputs are registered. data_clk never glitches.
- States and transitions:
  - IDLE -> WAIT_WORD on start. word_cnt cleared.
  - WAIT_WORD: in_ready=1, data_clk=0. On in_valid&in_ready: cfg_out.data_in <= in_data, go to SETUP. With no valid word, wait indefinitely with data_clk low.
  - SETUP: data_clk=0 for CLK_DIV cycles (data_in stable = setup time), then -> PULSE.
  - PULSE: data_clk=1 for CLK_DIV cycles; data_in held. On exit, word_cnt++. Then -> WAIT_WORD if word_cnt+1 < CHAIN_LEN, else DONE.
  - DONE: done=1 for one cycle, data_clk=0, -> IDLE.
- data_in changes only while data_clk=0, and only at WAIT_WORD->SETUP.
- Hold time is >= 1 clk after the data_clk falling edge.
- Latency with continuous in_valid:
  - per word 2*CLK_DIV+1 cycles;
  - start to done = 1 + CHAIN_LEN*(2*CLK_DIV+1) cycles.
- start while busy: ignored, with no effect on the current transaction.
- in_valid outside WAIT_WORD: not accepted (in_ready=0). Host holds the word.
- data_in keeps its last word after the transaction and is reset only by reset.
- CHAIN_LEN=1: single word, then DONE.
- Reset mid-transaction: chain contents are partial/undefined. Host must restart the full transaction.

Optional Feature:
- Macro: CFG_CHAIN_READBACK_EN.
- With it defined, the block adds:
  - port cfg_in (config_if.slave), connected to the chain tail;
  - outputs rd_data (fp::WORD_LENGTH, reset 0) and rd_valid (1, reset 0).
- Readback sampling: on the last clk cycle of each PULSE phase, rd_data <= cfg_in.data_in and rd_valid pulses one cycle.
- After a full transaction, the old chain contents have been read out, the tail word first.
- Without the macro: no cfg_in, rd_data or rd_valid ports, and no readback logic.

Decomposition:
- Package cfg_pkg:
  - state enum cfg_wr_state_t {IDLE, WAIT_WORD, SETUP, PULSE, DONE};
  - word type is fp::fpType and width fp::WORD_LENGTH from package fp (reused, not redefined).
- One sub-module, cfg_phase_cnt: loadable down-counter of $clog2(CLK_DIV+1) bits with a terminal-count flag, used for the SETUP and PULSE phase lengths.

Test Plan:
- CHAIN_LEN=4, CLK_DIV=2, words 1,2,3,4 with continuous in_valid, into a 4-stage model chain. Required response:
  - exactly 4 data_clk rising edges;
  - model chain holds {4,3,2,1} from head to tail;
  - done pulses 21 cycles after start;
  - word_cnt=4 at done.
- Stall: in_valid low for 10 cycles before word 3. Required: data_clk stays 0 and in_ready stays 1 during the gap; final chain contents unchanged vs the previous test.
- start asserted during PULSE of word 2. Required: ignored; single done; exactly 4 pulses.
- Async reset asserted mid-PULSE of word 2. Required:
  - data_clk 0 in the same cycle;
  - busy 0, data_in 0;
  - next start shifts 4 full words correctly.
- CHAIN_LEN=1, CLK_DIV=1, word 7. Required: one pulse; data_in stable through SETUP and PULSE; done 4 cycles after start.
- CFG_CHAIN_READBACK_EN, chain preloaded {5,6,7,8} (head to tail), write 1..4. Required: rd_valid pulses 4 times with rd_data 8,7,6,5.
